// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared state encoding and sizing for the FIFO reader.
// Build option FIFO_READER_BURST_EN changes the IDLE start condition.
package fifo_reader_pkg;

    localparam int DEF_DATA_SIZE = 4;
    localparam int SKID_DEPTH    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    // Room for one more read once buffered and in-flight words are counted.
    function automatic logic has_room(
        input logic [1:0] occ,
        input logic       busy
    );
        return ({1'b0, occ} + {2'b00, busy}) < 3'(SKID_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// fifo_reader_skid: two-entry in-order skid buffer between the FIFO
// read port and the downstream valid/ready interface.
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] push_data,
    input  logic                 ready,
    output logic                 valid,
    output logic [DATA_SIZE-1:0] data,
    output logic [1:0]           count
);

    logic [DATA_SIZE-1:0] head;
    logic [DATA_SIZE-1:0] tail;
    logic                 pop;

    assign valid = (count != 2'd0);
    assign data  = head;
    assign pop   = valid && ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0)
                        head <= push_data;
                    else
                        tail <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Count stays put; the new word lands behind the survivor.
                    if (count == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: pops a registered-output FIFO and delivers words downstream.
// Define FIFO_READER_BURST_EN to start only once almost_empty is low.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic                 almost_empty,
    input  logic                 fifo_error,
    input  logic [DATA_SIZE-1:0] buffer_out,
    output logic                 read,
    output logic                 out_valid,
    output logic [DATA_SIZE-1:0] out_data,
    input  logic                 out_ready,
    output logic [7:0]           words_read,
    output logic                 err
);

    state_t     state;
    logic       in_flight;
    logic [1:0] occupancy;
    logic       start;
    logic       transfer;

`ifdef FIFO_READER_BURST_EN
    assign start = !almost_empty;
`else
    logic unused_flags;
    assign unused_flags = almost_empty;
    assign start        = !fifo_empty;
`endif

    // Decided from registered occupancy and in-flight state, never from out_ready.
    assign read = (state == RUN) && !fifo_empty
                  && has_room(occupancy, in_flight);

    assign transfer = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            in_flight  <= 1'b0;
            words_read <= 8'd0;
            err        <= 1'b0;
        end else begin
            in_flight <= read;
            if (transfer)
                words_read <= words_read + 8'd1;
            if (fifo_error) begin
                state <= ERR;
                err   <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: if (start) state <= RUN;
                    RUN: begin
                        if (fifo_empty && !in_flight)
                            state <= IDLE;
                    end
                    ERR:     err <= 1'b1;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    fifo_reader_skid #(
        .DATA_SIZE(DATA_SIZE)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (in_flight),
        .push_data (buffer_out),
        .ready     (out_ready),
        .valid     (out_valid),
        .data      (out_data),
        .count     (occupancy)
    );

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: FIFO model plus scoreboard around fifo_reader.
// Scenario f changes behaviour when FIFO_READER_BURST_EN is defined.
module tb_fifo_reader;
    import fifo_reader_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fifo_empty = 1'b1;
    logic       almost_empty = 1'b1;
    logic       fifo_error = 1'b0;
    logic [3:0] buffer_out = 4'h0;
    logic       read;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready = 1'b0;
    logic [7:0] words_read;
    logic       err;

    logic [3:0] fifo_q[$];
    logic [3:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         reads_seen = 0;
    logic [7:0] exp_wr = 8'd0;
    logic       held = 1'b0;
    logic [3:0] held_data = 4'h0;

    fifo_reader dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .almost_empty (almost_empty),
        .fifo_error   (fifo_error),
        .buffer_out   (buffer_out),
        .read         (read),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .words_read   (words_read),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    endtask

    // Registered-output FIFO: pops on read, flags reflect post-pop fill.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_q.delete();
            fifo_empty   <= 1'b1;
            almost_empty <= 1'b1;
            buffer_out   <= 4'h0;
        end else begin
            if (read && fifo_q.size() > 0)
                buffer_out <= fifo_q.pop_front();
            fifo_empty   <= (fifo_q.size() == 0);
            almost_empty <= (fifo_q.size() <= 1);
        end
    end

    // Monitor samples mid-cycle, before the edge that performs a transfer.
    always begin
        @(negedge clk);
        #2;
        if (reset) begin
            held = 1'b0;
        end else begin
            if (read)
                reads_seen++;
            if (held)
                chk("hold", {out_valid, out_data}, {1'b1, held_data});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_extra", {31'b0, out_valid}, 0);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                    exp_wr++;
                end
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
        end
    end

    task automatic load(input logic [3:0] w, input bit expect_out);
        fifo_q.push_back(w);
        if (expect_out)
            exp_q.push_back(w);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        exp_q.delete();
        exp_wr = 8'd0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int r0;
        int n;
        logic [3:0] w;

        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_words", words_read, 0);
        chk("rst_err", err, 0);
        chk("rst_read", read, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // a) three words, downstream always ready
        out_ready = 1'b1;
        load(4'h3, 1);
        load(4'h7, 1);
        load(4'hA, 1);
        drain("a", 50);
        chk("a_words", words_read, 3);
        chk("a_idle", dut.state, IDLE);

        // b) five words against a stalled consumer
        out_ready = 1'b0;
        r0 = reads_seen;
        load(4'h5, 1);
        load(4'hC, 1);
        load(4'h1, 1);
        load(4'hE, 1);
        load(4'h9, 1);
        repeat (10) @(negedge clk);
        #3;
        chk("b_reads", reads_seen - r0, 2);
        chk("b_occ", dut.occupancy, 2);
        chk("b_valid", out_valid, 1);
        chk("b_data", out_data, 4'h5);
        @(negedge clk);
        out_ready = 1'b1;
        drain("b", 60);
        chk("b_words", words_read, 8);

        // d) asynchronous reset with a full skid buffer
        out_ready = 1'b0;
        load(4'h4, 1);
        load(4'h6, 1);
        load(4'h8, 1);
        load(4'hB, 1);
        repeat (8) @(negedge clk);
        chk("d_occ", dut.occupancy, 2);
        #1 reset = 1'b1;
        #1;
        chk("d_valid", out_valid, 0);
        chk("d_words", words_read, 0);
        chk("d_data", out_data, 0);
        exp_q.delete();
        exp_wr = 8'd0;
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("d_post_valid", out_valid, 0);
        chk("d_post_words", words_read, 0);
        @(negedge clk);

        // c) error while one word is buffered
        out_ready = 1'b0;
        load(4'h6, 1);
        load(4'hB, 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("c_start", out_valid, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("c_occ", dut.occupancy, 1);
        fifo_error = 1'b1;
        @(negedge clk);
        fifo_error = 1'b0;
        chk("c_err", err, 1);
        load(4'h2, 0);
        load(4'h3, 0);
        r0 = reads_seen;
        repeat (5) @(negedge clk);
        #3;
        chk("c_noread", reads_seen - r0, 0);
        chk("c_state", dut.state, ERR);
        chk("c_valid", out_valid, 1);
        @(negedge clk);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("c_drain", exp_q.size(), 0);
        chk("c_words", words_read, 2);
        repeat (5) @(negedge clk);
        chk("c_sticky", err, 1);
        do_reset();
        chk("c_clear", err, 0);

        // e) 256 words wrap the delivered-word counter
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            w = 4'($urandom_range(0, 15));
            load(w, 1);
        end
        drain("e", 2000);
        chk("e_model", words_read, exp_wr);
        chk("e_wrap", words_read, 0);

        // f) start condition
        load(4'h2, 1);
        @(posedge clk);
        #2 chk("f_pre", read, 0);
`ifdef FIFO_READER_BURST_EN
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2 chk("f_ae_hold", read, 0);
        end
        chk("f_ae", almost_empty, 1);
        @(negedge clk);
        load(4'h9, 1);
        load(4'hD, 1);
        @(posedge clk);
        #2 chk("f_ae_fall", almost_empty, 0);
        chk("f_pre2", read, 0);
`endif
        @(posedge clk);
        #2 chk("f_read", read, 1);
        @(negedge clk);
        drain("f", 50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
